// File: rtl/mmm_pkg.sv
// Shared fetch-stage parameters, the line-fetcher state type and a line-alignment helper.
package mmm_pkg;
  localparam int XLEN          = 32;
  localparam int ILEN          = 32;
  localparam int ICACHE_OFFSET = 2;
  localparam int OFFSET        = 2;
  localparam int LINE_OFF      = ICACHE_OFFSET + OFFSET;
  localparam int LINE_W        = 8 << LINE_OFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetcher_state_t;

  // Clears the byte-in-line bits so two PCs in the same line compare equal.
  function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] mask;
    mask = '1;
    mask = mask << LINE_OFF;
    return addr & mask;
  endfunction
endpackage

// File: rtl/presence_checker.sv
// Fetch-stage helper: tells the line fetcher whether pc hits the held line or the refill in flight.
module presence_checker
  import mmm_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] line_pc_i,
  input  logic            line_valid_i,
  input  logic [XLEN-1:0] prev_pc_i,
  input  logic            refill_pending_i,
  output logic            here_o,
  output logic            will_be_here_o
);
  logic [XLEN-1:0] w_pc_line;

  assign w_pc_line      = line_align(pc_i);
  assign here_o         = line_valid_i & (w_pc_line == line_pc_i);
  assign will_be_here_o = refill_pending_i & (w_pc_line == prev_pc_i);
endmodule

// File: rtl/icache_line_fetcher.sv
// Single-line instruction buffer: serves hits combinationally and refills one line at a time
// from the icache, with flush able to discard a refill that is already in flight.
module icache_line_fetcher
  import mmm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_req_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic                  flush_i,
  input  logic                  here_i,
  input  logic                  will_be_here_i,
  output logic [XLEN-1:0]       line_pc_o,
  output logic                  line_valid_o,
  output logic [XLEN-1:0]       prev_pc_o,
  output logic [ILEN-1:0]       instr_o,
  output logic                  instr_valid_o,
  output logic                  icache_req_valid_o,
  input  logic                  icache_req_ready_i,
  output logic [XLEN-1:0]       icache_req_addr_o,
  input  logic                  icache_resp_valid_i,
  input  logic [LINE_W-1:0]     icache_resp_data_i,
  output fetcher_state_t        state_o
);
  fetcher_state_t          r_state, w_state_next;
  logic                    r_line_valid;
  logic                    r_discard;
  logic [XLEN-1:0]         r_line_pc;
  logic [XLEN-1:0]         r_prev_pc;
  logic [LINE_W-1:0]       r_line_data;
  logic                    w_miss;
  logic                    w_resp_in_wait;
  logic                    w_fill;
  logic [ICACHE_OFFSET-1:0] w_word_idx;

  assign w_miss         = fetch_req_i & ~here_i & ~will_be_here_i & ~flush_i;
  assign w_resp_in_wait = (r_state == WAIT) & icache_resp_valid_i;
  assign w_fill         = w_resp_in_wait & ~r_discard & ~flush_i;
  assign w_word_idx     = pc_i[LINE_OFF-1:OFFSET];

  // Request handshake: valid/addr are held from entering REQ until the edge where valid & ready.
  always_comb begin
    w_state_next       = r_state;
    icache_req_valid_o = 1'b0;
    unique case (r_state)
      IDLE: if (w_miss) w_state_next = REQ;
      REQ: begin
        icache_req_valid_o = 1'b1;
        if (icache_req_ready_i) w_state_next = WAIT;
      end
      WAIT: if (icache_resp_valid_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_line_valid <= 1'b0;
      r_discard    <= 1'b0;
      r_line_pc    <= '0;
      r_prev_pc    <= '0;
      r_line_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && w_miss) r_prev_pc <= line_align(pc_i);
      // The response retires the refill, so the discard marker dies with it.
      if (w_resp_in_wait) r_discard <= 1'b0;
      else if (flush_i && (r_state != IDLE)) r_discard <= 1'b1;
      if (flush_i) r_line_valid <= 1'b0;
      else if (w_fill) r_line_valid <= 1'b1;
      if (w_fill) begin
        r_line_data <= icache_resp_data_i;
        r_line_pc   <= r_prev_pc;
      end
    end
  end

  assign line_pc_o         = r_line_pc;
  assign line_valid_o      = r_line_valid;
  assign prev_pc_o         = r_prev_pc;
  assign icache_req_addr_o = r_prev_pc;
  assign instr_valid_o     = fetch_req_i & here_i & ~flush_i;
  assign instr_o           = r_line_data[w_word_idx*ILEN +: ILEN];
  assign state_o           = r_state;
endmodule
